// File: rtl/soc_event_pkg.sv
// soc_event_pkg
// Shared types and default sizes for the SoC event arbiter.
//   event_id_t          : event ID as seen by the FC event FIFO
//   DEF_*               : default parameter values for soc_event_arbiter
//   idx_width()         : index width for an N-entry source vector (at least 1)
package soc_event_pkg;

    localparam int DEF_NB_SOURCES     = 32;
    localparam int DEF_EVENT_ID_WIDTH = 8;
    localparam int DEF_CNT_WIDTH      = 2;

    typedef logic [DEF_EVENT_ID_WIDTH-1:0] event_id_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/soc_event_rr_arbiter.sv
// soc_event_rr_arbiter
// Combinational round-robin pick: the first set request at or after ptr_i,
// wrapping from NB_SOURCES-1 back to 0. The pointer register is owned by the caller.
//   req_i     in   NB_SOURCES  request vector
//   ptr_i     in   IDX_W       search start index (must be < NB_SOURCES)
//   gnt_o     out  NB_SOURCES  one-hot grant (all zero when no request)
//   idx_o     out  IDX_W       index of the granted request
//   any_gnt_o out  1           at least one request present
module soc_event_rr_arbiter
    import soc_event_pkg::*;
#(
    parameter int NB_SOURCES = DEF_NB_SOURCES,
    parameter int IDX_W      = idx_width(NB_SOURCES)
) (
    input  logic [NB_SOURCES-1:0] req_i,
    input  logic [IDX_W-1:0]      ptr_i,
    output logic [NB_SOURCES-1:0] gnt_o,
    output logic [IDX_W-1:0]      idx_o,
    output logic                  any_gnt_o
);

    always_comb begin
        int               j;
        logic [IDX_W-1:0] cand;
        j         = 0;
        cand      = '0;
        gnt_o     = '0;
        idx_o     = '0;
        any_gnt_o = 1'b0;
        for (int i = 0; i < NB_SOURCES; i++) begin
            j = int'(ptr_i) + i;
            if (j >= NB_SOURCES) begin
                j = j - NB_SOURCES;
            end
            cand = IDX_W'(j);
            if (!any_gnt_o && req_i[cand]) begin
                any_gnt_o   = 1'b1;
                gnt_o[cand] = 1'b1;
                idx_o       = cand;
            end
        end
    end

endmodule

// File: rtl/soc_event_arbiter.sv
// soc_event_arbiter
// Counts event pulses per source and serialises them, round-robin, as event IDs
// into a single-entry valid/ready output register feeding the FC event FIFO.
//   clk_i        in   1               clock
//   rst_ni       in   1               asynchronous active-low reset
//   src_evt_i    in   NB_SOURCES      event pulses
//   src_en_i     in   NB_SOURCES      source enable mask
//   ovf_clr_i    in   NB_SOURCES      clear for sticky overflow flags
//   evt_valid_o  out  1               output event valid
//   evt_data_o   out  EVENT_ID_WIDTH  output event ID (ID_OFFSET + source)
//   evt_fulln_i  in   1               consumer ready
//   ovf_o        out  NB_SOURCES      sticky counter-saturation flags
//   pending_o    out  1               some enabled source has a non-zero count
module soc_event_arbiter
    import soc_event_pkg::*;
#(
    parameter int NB_SOURCES     = DEF_NB_SOURCES,
    parameter int EVENT_ID_WIDTH = DEF_EVENT_ID_WIDTH,
    parameter int ID_OFFSET      = 0,
    parameter int CNT_WIDTH      = DEF_CNT_WIDTH
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [NB_SOURCES-1:0]     src_evt_i,
    input  logic [NB_SOURCES-1:0]     src_en_i,
    input  logic [NB_SOURCES-1:0]     ovf_clr_i,
    output logic                      evt_valid_o,
    output logic [EVENT_ID_WIDTH-1:0] evt_data_o,
    input  logic                      evt_fulln_i,
    output logic [NB_SOURCES-1:0]     ovf_o,
    output logic                      pending_o
);

    localparam int                   IDX_W   = idx_width(NB_SOURCES);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    if (NB_SOURCES < 1 || NB_SOURCES > 64) begin : g_bad_nb_sources
        $error("soc_event_arbiter: NB_SOURCES must be within 1..64");
    end
    if ((longint'(ID_OFFSET) + longint'(NB_SOURCES) - 1) >= (longint'(1) << EVENT_ID_WIDTH)) begin : g_bad_id_range
        $error("soc_event_arbiter: highest event ID does not fit in EVENT_ID_WIDTH");
    end

    logic [CNT_WIDTH-1:0]      cnt_q [NB_SOURCES];
    logic [CNT_WIDTH-1:0]      cnt_d [NB_SOURCES];
    logic [NB_SOURCES-1:0]     ovf_q, ovf_d;
    logic [NB_SOURCES-1:0]     elig, inc, dec, gnt;
    logic [IDX_W-1:0]          ptr_q, ptr_d, gnt_idx;
    logic                      any_gnt, load_ok, load;
    logic                      valid_q, valid_d;
    logic [EVENT_ID_WIDTH-1:0] data_q, data_d;

    always_comb begin
        elig = '0;
        for (int k = 0; k < NB_SOURCES; k++) begin
            elig[k] = (cnt_q[k] != '0) && src_en_i[k];
        end
    end

    soc_event_rr_arbiter #(
        .NB_SOURCES (NB_SOURCES),
        .IDX_W      (IDX_W)
    ) u_rr (
        .req_i      (elig),
        .ptr_i      (ptr_q),
        .gnt_o      (gnt),
        .idx_o      (gnt_idx),
        .any_gnt_o  (any_gnt)
    );

    // The output register can take a new event when empty or when its current
    // event leaves this cycle.
    assign load_ok = !valid_q || evt_fulln_i;
    assign load    = load_ok && any_gnt;
    assign inc     = src_evt_i & src_en_i;
    assign dec     = gnt & {NB_SOURCES{load}};

    always_comb begin
        for (int k = 0; k < NB_SOURCES; k++) begin
            cnt_d[k] = cnt_q[k];
            ovf_d[k] = ovf_q[k] && !ovf_clr_i[k];
            if (inc[k] && !dec[k]) begin
                if (cnt_q[k] == CNT_MAX) begin
                    ovf_d[k] = 1'b1;          // setting beats a same-cycle clear
                end else begin
                    cnt_d[k] = cnt_q[k] + CNT_WIDTH'(1);
                end
            end else if (dec[k] && !inc[k]) begin
                cnt_d[k] = cnt_q[k] - CNT_WIDTH'(1);
            end
        end
    end

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        ptr_d   = ptr_q;
        if (load) begin
            valid_d = 1'b1;
            data_d  = EVENT_ID_WIDTH'(ID_OFFSET + int'(gnt_idx));
            ptr_d   = (gnt_idx == IDX_W'(NB_SOURCES - 1)) ? '0 : gnt_idx + IDX_W'(1);
        end else if (valid_q && evt_fulln_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 0; k < NB_SOURCES; k++) begin
                cnt_q[k] <= '0;
            end
            ovf_q   <= '0;
            ptr_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            for (int k = 0; k < NB_SOURCES; k++) begin
                cnt_q[k] <= cnt_d[k];
            end
            ovf_q   <= ovf_d;
            ptr_q   <= ptr_d;
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign evt_valid_o = valid_q;
    assign evt_data_o  = data_q;
    assign ovf_o       = ovf_q;
    assign pending_o   = |elig;

endmodule

// File: tb/tb_soc_event_arbiter.sv
// tb_soc_event_arbiter
// Self-checking bench for soc_event_arbiter: a table of per-cycle vectors,
// hand-written multi-cycle sequences and a randomized phase checked against a
// behavioural model built on integer counts.
module tb_soc_event_arbiter;
    import soc_event_pkg::*;

    localparam int N    = 32;
    localparam int CW   = 2;
    localparam int CMAX = 3;
    localparam int IDO  = 0;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [N-1:0]  src_evt, src_en, ovf_clr;
    logic          fulln;
    logic          evt_valid;
    event_id_t     evt_data;
    logic [N-1:0]  ovf;
    logic          pending;

    int n_err = 0;
    int n_chk = 0;

    always #5 clk = ~clk;

    soc_event_arbiter #(
        .NB_SOURCES     (N),
        .EVENT_ID_WIDTH (8),
        .ID_OFFSET      (IDO),
        .CNT_WIDTH      (CW)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .src_evt_i   (src_evt),
        .src_en_i    (src_en),
        .ovf_clr_i   (ovf_clr),
        .evt_valid_o (evt_valid),
        .evt_data_o  (evt_data),
        .evt_fulln_i (fulln),
        .ovf_o       (ovf),
        .pending_o   (pending)
    );

    // ---------------- behavioural model ----------------
    int m_cnt [N];
    bit m_ovf [N];
    int m_ptr;
    bit m_valid;
    int m_data;

    function automatic void model_reset();
        for (int k = 0; k < N; k++) begin
            m_cnt[k] = 0;
            m_ovf[k] = 0;
        end
        m_ptr   = 0;
        m_valid = 0;
        m_data  = 0;
    endfunction

    function automatic void model_step();
        int win;
        int k;
        bit can_load, inc, dec, set_ovf;
        win      = -1;
        can_load = !m_valid || fulln;
        if (can_load) begin
            for (int i = 0; i < N; i++) begin
                k = (m_ptr + i) % N;
                if (win < 0 && m_cnt[k] > 0 && src_en[k]) win = k;
            end
        end
        for (int s = 0; s < N; s++) begin
            inc     = src_evt[s] && src_en[s];
            dec     = (s == win);
            set_ovf = inc && !dec && (m_cnt[s] == CMAX);
            if (inc && !dec && !set_ovf) m_cnt[s] = m_cnt[s] + 1;
            else if (dec && !inc)        m_cnt[s] = m_cnt[s] - 1;
            if (set_ovf)         m_ovf[s] = 1;
            else if (ovf_clr[s]) m_ovf[s] = 0;
        end
        if (win >= 0) begin
            m_valid = 1;
            m_data  = IDO + win;
            m_ptr   = (win + 1) % N;
        end else if (m_valid && fulln) begin
            m_valid = 0;
        end
    endfunction

    function automatic bit model_pending();
        bit p;
        p = 0;
        for (int k = 0; k < N; k++) if (m_cnt[k] > 0 && src_en[k]) p = 1;
        return p;
    endfunction

    function automatic logic [N-1:0] model_ovf_vec();
        logic [N-1:0] v;
        v = '0;
        for (int k = 0; k < N; k++) v[k] = m_ovf[k];
        return v;
    endfunction

    // ---------------- helpers ----------------
    function automatic logic [N-1:0] bitv(input int k);
        logic [N-1:0] b;
        b    = '0;
        b[k] = 1'b1;
        return b;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic check_model(input string tag);
        chk({tag, "_valid"}, 64'(evt_valid), 64'(m_valid));
        if (m_valid) chk({tag, "_data"}, 64'(evt_data), 64'(m_data));
        chk({tag, "_ovf"}, 64'(ovf), 64'(model_ovf_vec()));
        chk({tag, "_pending"}, 64'(pending), 64'(model_pending()));
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [N-1:0] evt;
        logic         fulln;
        logic         exp_valid;
        event_id_t    exp_data;
        logic         exp_pending;
    } vec_t;

    vec_t vecs [16];

    function automatic vec_t mkvec(input logic [N-1:0] e, input logic f, input logic v,
                                   input int d, input logic p);
        vec_t r;
        r.evt         = e;
        r.fulln       = f;
        r.exp_valid   = v;
        r.exp_data    = event_id_t'(d);
        r.exp_pending = p;
        return r;
    endfunction

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        int ids;

        // pulses 3,7,31 together, then 3,7 again from pointer 0
        vecs[0]  = mkvec(bitv(3) | bitv(7) | bitv(31), 1, 0, 0, 1);
        vecs[1]  = mkvec('0, 1, 1, 3, 1);
        vecs[2]  = mkvec('0, 1, 1, 7, 1);
        vecs[3]  = mkvec('0, 1, 1, 31, 0);
        vecs[4]  = mkvec('0, 1, 0, 0, 0);
        vecs[5]  = mkvec(bitv(3) | bitv(7), 1, 0, 0, 1);
        vecs[6]  = mkvec('0, 1, 1, 3, 1);
        vecs[7]  = mkvec('0, 1, 1, 7, 0);
        vecs[8]  = mkvec('0, 1, 0, 0, 0);
        // single pulse on source 5: valid for exactly one cycle, two edges later
        vecs[9]  = mkvec(bitv(5), 1, 0, 0, 1);
        vecs[10] = mkvec('0, 1, 1, 5, 0);
        vecs[11] = mkvec('0, 1, 0, 0, 0);
        // pulse coinciding with its own grant keeps the count
        vecs[12] = mkvec(bitv(9), 1, 0, 0, 1);
        vecs[13] = mkvec(bitv(9), 1, 1, 9, 1);
        vecs[14] = mkvec('0, 1, 1, 9, 0);
        vecs[15] = mkvec('0, 1, 0, 0, 0);

        rst_n   = 1'b1;
        src_evt = '0;
        src_en  = '1;
        ovf_clr = '0;
        fulln   = 1'b1;
        model_reset();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_valid", 64'(evt_valid), 0);
        chk("rst_data", 64'(evt_data), 0);
        chk("rst_ovf", 64'(ovf), 0);
        chk("rst_pending", 64'(pending), 0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            src_evt = vecs[i].evt;
            fulln   = vecs[i].fulln;
            cycle();
            chk($sformatf("vec%0d_valid", i), 64'(evt_valid), 64'(vecs[i].exp_valid));
            if (vecs[i].exp_valid)
                chk($sformatf("vec%0d_data", i), 64'(evt_data), 64'(vecs[i].exp_data));
            chk($sformatf("vec%0d_pending", i), 64'(pending), 64'(vecs[i].exp_pending));
        end
        src_evt = '0;

        // stall: ID 2 held for 10 cycles while 1 and 4 queue behind it
        fulln   = 1'b0;
        src_evt = bitv(2);
        cycle();
        src_evt = '0;
        cycle();
        chk("stall_load_valid", 64'(evt_valid), 1);
        chk("stall_load_data", 64'(evt_data), 2);
        src_evt = bitv(1) | bitv(4);
        cycle();
        src_evt = '0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            chk("stall_hold_valid", 64'(evt_valid), 1);
            chk("stall_hold_data", 64'(evt_data), 2);
            chk("stall_hold_pending", 64'(pending), 1);
        end
        fulln = 1'b1;
        cycle();
        chk("stall_rel_a", 64'(evt_data), 4);
        cycle();
        chk("stall_rel_b", 64'(evt_data), 1);
        cycle();
        chk("stall_rel_empty", 64'(evt_valid), 0);

        // saturation: 5 pulses on source 1 with consumer stalled
        fulln = 1'b0;
        for (int i = 0; i < 5; i++) begin
            src_evt = bitv(1);
            cycle();
        end
        src_evt = '0;
        chk("sat_valid", 64'(evt_valid), 1);
        chk("sat_data", 64'(evt_data), 1);
        chk("sat_ovf", 64'(ovf), 64'(bitv(1)));
        fulln = 1'b1;
        ids   = 0;
        for (int i = 0; i < 8; i++) begin
            if (evt_valid && evt_data == 1) ids++;
            cycle();
        end
        chk("sat_id_count", 64'(ids), 4);
        chk("sat_ovf_sticky", 64'(ovf), 64'(bitv(1)));
        ovf_clr = bitv(1);
        cycle();
        ovf_clr = '0;
        chk("sat_ovf_cleared", 64'(ovf), 0);

        // enable mask: disabled source keeps its count, drops new pulses
        fulln   = 1'b0;
        src_evt = bitv(0);
        cycle();
        src_evt = '0;
        cycle();
        chk("en_occupy", 64'(evt_data), 0);
        src_evt = bitv(4);
        cycle();
        src_evt = '0;
        chk("en_pending_on", 64'(pending), 1);
        src_en[4] = 1'b0;
        #1;
        chk("en_pending_off", 64'(pending), 0);
        src_evt = bitv(4);
        fulln   = 1'b1;
        cycle();
        src_evt = '0;
        chk("en_masked_a", 64'(evt_valid), 0);
        cycle();
        chk("en_masked_b", 64'(evt_valid), 0);
        chk("en_masked_pend", 64'(pending), 0);
        src_en[4] = 1'b1;
        src_evt   = bitv(4);
        cycle();
        src_evt = '0;
        chk("en_resume_data", 64'(evt_data), 4);
        chk("en_resume_pend", 64'(pending), 1);
        cycle();
        chk("en_again_valid", 64'(evt_valid), 1);
        chk("en_again_data", 64'(evt_data), 4);
        chk("en_again_pend", 64'(pending), 0);
        cycle();
        chk("en_done", 64'(evt_valid), 0);

        // reset while an event is held and counters/flags are set
        fulln = 1'b0;
        for (int i = 0; i < 5; i++) begin
            src_evt = bitv(3) | bitv(8);
            cycle();
        end
        src_evt = '0;
        check_model("pre_rst");
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("mid_rst_valid", 64'(evt_valid), 0);
        chk("mid_rst_data", 64'(evt_data), 0);
        chk("mid_rst_ovf", 64'(ovf), 0);
        chk("mid_rst_pending", 64'(pending), 0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        fulln = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("post_rst_idle", 64'(evt_valid), 0);
        end

        // randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            src_evt = $urandom & $urandom & $urandom;
            src_en  = ~($urandom & $urandom & $urandom);
            ovf_clr = $urandom & $urandom & $urandom & $urandom;
            if (i < 300) fulln = ($urandom_range(0, 3) != 0);
            else         fulln = ($urandom_range(0, 3) == 0);
            cycle();
            check_model("rand");
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
